tournament_predictor: RTL and testbench

- Direction predictor that feeds the stall control unit and consumes its training strobes.
- Produces the IF-stage prediction `if_br_pr` from the fetch PC.
- Carries the local, global and final predictions plus their table indices into ID, where they drive `id_local_pr`, `id_global_pr` and `id_br_pr`.
- Trains the local PHT, global PHT and chooser from `ghr_load`, `bht_load`, `increment_pht`/`decrement_pht` and `increment_tournament_pht`/`decrement_tournament_pht`.

---
 rtl/tournament_predictor.sv | 213 +++++++++++++++++++++
 tb/tb_tournament_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_predictor.sv
// ----------------------------------------------------------------------------
// tournament_predictor
//
// Tournament branch direction predictor. It combines a local (per-branch
// history) predictor, a global (gshare) predictor and a per-PC chooser.
//
// The IF stage reads all three tables combinationally from the fetch PC. The
// predictions and the table indices used are carried into ID. Training is
// applied later, using only those ID-held indices, when the stall control
// unit resolves the branch.
//
// Ports:
//   clk                       in   clock, rising edge
//   rst                       in   asynchronous reset, active low
//   if_pc[31:0]               in   fetch PC
//   if_id_reg_load            in   capture the IF prediction into ID
//   if_id_reg_flush           in   clear ID (has priority over load)
//   ghr_load                  in   shift the resolved outcome into the GHR
//   bht_load                  in   shift the resolved outcome into the ID
//                                  branch's local history
//   increment_pht             in   ID branch taken: both PHTs count up
//   decrement_pht             in   ID branch not taken: both PHTs count down
//   increment_tournament_pht  in   global was right, local wrong: favour global
//   decrement_tournament_pht  in   local was right, global wrong: favour local
//   if_br_pr                  out  IF final prediction (combinational)
//   id_local_pr               out  local prediction of the ID instruction
//   id_global_pr              out  global prediction of the ID instruction
//   id_br_pr                  out  final prediction of the ID instruction
// ----------------------------------------------------------------------------
module tournament_predictor #(
    parameter int BHT_IDX_W = 5,
    parameter int LHIST_W   = 6,
    parameter int GHR_W     = 6,
    parameter int CH_IDX_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_id_reg_load,
    input  logic        if_id_reg_flush,
    input  logic        ghr_load,
    input  logic        bht_load,
    input  logic        increment_pht,
    input  logic        decrement_pht,
    input  logic        increment_tournament_pht,
    input  logic        decrement_tournament_pht,
    output logic        if_br_pr,
    output logic        id_local_pr,
    output logic        id_global_pr,
    output logic        id_br_pr
);

    localparam int BHT_N  = 1 << BHT_IDX_W;
    localparam int LPHT_N = 1 << LHIST_W;
    localparam int GPHT_N = 1 << GHR_W;
    localparam int CH_N   = 1 << CH_IDX_W;

    // Highest PC bit used by any index; everything above it and the two
    // byte-offset bits are ignored.
    localparam int MAX_W = (BHT_IDX_W > GHR_W)
                         ? ((BHT_IDX_W > CH_IDX_W) ? BHT_IDX_W : CH_IDX_W)
                         : ((GHR_W > CH_IDX_W) ? GHR_W : CH_IDX_W);
    localparam int PC_HI = MAX_W + 1;

    // 2-bit saturating counter; the MSB is the taken / use-global decision.
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_RESET = 2'b01;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [LHIST_W-1:0] bht     [BHT_N];
    ctr_t               lpht    [LPHT_N];
    ctr_t               gpht    [GPHT_N];
    ctr_t               chooser [CH_N];
    logic [GHR_W-1:0]   ghr;

    // ------------------------------------------------------------------
    // IF read (pre-edge table state, no write-to-read bypass)
    // ------------------------------------------------------------------
    logic [BHT_IDX_W-1:0] if_bidx;
    logic [LHIST_W-1:0]   if_lidx;
    logic [GHR_W-1:0]     if_gidx;
    logic [CH_IDX_W-1:0]  if_cidx;
    logic                 if_local_pr;
    logic                 if_global_pr;
    logic                 if_use_global;

    assign if_bidx       = if_pc[BHT_IDX_W+1:2];
    assign if_lidx       = bht[if_bidx];
    assign if_gidx       = ghr ^ if_pc[GHR_W+1:2];
    assign if_cidx       = if_pc[CH_IDX_W+1:2];
    assign if_local_pr   = lpht[if_lidx][1];
    assign if_global_pr  = gpht[if_gidx][1];
    assign if_use_global = chooser[if_cidx][1];
    assign if_br_pr      = if_use_global ? if_global_pr : if_local_pr;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:PC_HI+1], if_pc[1:0]};

    // ------------------------------------------------------------------
    // ID capture
    // ------------------------------------------------------------------
    logic                 id_valid;
    logic [BHT_IDX_W-1:0] id_bidx;
    logic [LHIST_W-1:0]   id_lidx;
    logic [GHR_W-1:0]     id_gidx;
    logic [CH_IDX_W-1:0]  id_cidx;

    // NOTE: state is written with non-blocking assignments so every flop in
    // this module samples pre-edge values, which is what lets capture and
    // training share an edge without seeing each other's results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid     <= 1'b0;
            id_local_pr  <= 1'b0;
            id_global_pr <= 1'b0;
            id_br_pr     <= 1'b0;
            id_bidx      <= '0;
            id_lidx      <= '0;
            id_gidx      <= '0;
            id_cidx      <= '0;
        end else if (if_id_reg_flush) begin
            id_valid     <= 1'b0;
            id_local_pr  <= 1'b0;
            id_global_pr <= 1'b0;
            id_br_pr     <= 1'b0;
            id_bidx      <= '0;
            id_lidx      <= '0;
            id_gidx      <= '0;
            id_cidx      <= '0;
        end else if (if_id_reg_load) begin
            id_valid     <= 1'b1;
            id_local_pr  <= if_local_pr;
            id_global_pr <= if_global_pr;
            id_br_pr     <= if_br_pr;
            id_bidx      <= if_bidx;
            id_lidx      <= if_lidx;
            id_gidx      <= if_gidx;
            id_cidx      <= if_cidx;
        end
    end

    // ------------------------------------------------------------------
    // Training (ID-held indices only; an inc/dec pair both high is a no-op)
    // ------------------------------------------------------------------
    logic outcome;
    logic pht_up;
    logic pht_dn;
    logic ch_up;
    logic ch_dn;

    assign outcome = increment_pht;
    assign pht_up  = id_valid &  increment_pht & ~decrement_pht;
    assign pht_dn  = id_valid & ~increment_pht &  decrement_pht;
    assign ch_up   = id_valid &  increment_tournament_pht & ~decrement_tournament_pht;
    assign ch_dn   = id_valid & ~increment_tournament_pht &  decrement_tournament_pht;

    // NOTE: the tables are small flop arrays and must come out of reset in a
    // known weakly-not-taken state, so every entry is reset explicitly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LPHT_N; i++) lpht[i] <= CTR_RESET;
            for (int i = 0; i < GPHT_N; i++) gpht[i] <= CTR_RESET;
        end else if (pht_up) begin
            lpht[id_lidx] <= sat_inc(lpht[id_lidx]);
            gpht[id_gidx] <= sat_inc(gpht[id_gidx]);
        end else if (pht_dn) begin
            lpht[id_lidx] <= sat_dec(lpht[id_lidx]);
            gpht[id_gidx] <= sat_dec(gpht[id_gidx]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH_N; i++) chooser[i] <= CTR_RESET;
        end else if (ch_up) begin
            chooser[id_cidx] <= sat_inc(chooser[id_cidx]);
        end else if (ch_dn) begin
            chooser[id_cidx] <= sat_dec(chooser[id_cidx]);
        end
    end

    // Histories only ever hold resolved outcomes of valid ID branches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
            for (int i = 0; i < BHT_N; i++) bht[i] <= '0;
        end else if (id_valid) begin
            if (ghr_load) ghr <= {ghr[GHR_W-2:0], outcome};
            if (bht_load) bht[id_bidx] <= {bht[id_bidx][LHIST_W-2:0], outcome};
        end
    end

    // ------------------------------------------------------------------
    // Simulation checks on the training strobes
    // ------------------------------------------------------------------
    a_pht_pair : assert property (@(posedge clk) disable iff (!rst)
        !(increment_pht && decrement_pht));

    a_tournament_pair : assert property (@(posedge clk) disable iff (!rst)
        !(increment_tournament_pht && decrement_tournament_pht));

endmodule

// File: tb/tb_tournament_predictor.sv
// ----------------------------------------------------------------------------
// tb_tournament_predictor
//
// Table-driven bench. Each record holds one cycle of stimulus, the expected
// combinational IF prediction for that cycle and the expected ID outputs
// after the edge. Expected ID outputs are queued when the stimulus is driven
// and popped once the edge has produced them. Hand-written sequences cover
// reset entry/exit and an asynchronous reset mid-run.
// Default parameters: bidx = pc[6:2], gidx = ghr ^ pc[7:2], cidx = pc[7:2].
// ----------------------------------------------------------------------------
module tb_tournament_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_id_reg_load;
    logic        if_id_reg_flush;
    logic        ghr_load;
    logic        bht_load;
    logic        increment_pht;
    logic        decrement_pht;
    logic        increment_tournament_pht;
    logic        decrement_tournament_pht;
    logic        if_br_pr;
    logic        id_local_pr;
    logic        id_global_pr;
    logic        id_br_pr;

    tournament_predictor dut (
        .clk                      (clk),
        .rst                      (rst),
        .if_pc                    (if_pc),
        .if_id_reg_load           (if_id_reg_load),
        .if_id_reg_flush          (if_id_reg_flush),
        .ghr_load                 (ghr_load),
        .bht_load                 (bht_load),
        .increment_pht            (increment_pht),
        .decrement_pht            (decrement_pht),
        .increment_tournament_pht (increment_tournament_pht),
        .decrement_tournament_pht (decrement_tournament_pht),
        .if_br_pr                 (if_br_pr),
        .id_local_pr              (id_local_pr),
        .id_global_pr             (id_global_pr),
        .id_br_pr                 (id_br_pr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control encoding: {load, flush, inc, dec, tinc, tdec, ghr_load, bht_load}
    localparam logic [7:0] LD  = 8'h80;
    localparam logic [7:0] FL  = 8'h40;
    localparam logic [7:0] INC = 8'h20;
    localparam logic [7:0] DEC = 8'h10;
    localparam logic [7:0] TI  = 8'h08;
    localparam logic [7:0] TD  = 8'h04;
    localparam logic [7:0] GL  = 8'h02;
    localparam logic [7:0] BL  = 8'h01;
    localparam logic [7:0] NONE = 8'h00;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic [3:0]  exp;    // {if_br_pr, id_local_pr, id_global_pr, id_br_pr}
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] exp_id;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    endtask

    task automatic add(input string name, input logic [31:0] pc,
                       input logic [7:0] ctrl, input logic [3:0] exp);
        vec_t v;
        v.name = name;
        v.pc   = pc;
        v.ctrl = ctrl;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [7:0] ctrl);
        if_pc                    = pc;
        if_id_reg_load           = ctrl[7];
        if_id_reg_flush          = ctrl[6];
        increment_pht            = ctrl[5];
        decrement_pht            = ctrl[4];
        increment_tournament_pht = ctrl[3];
        decrement_tournament_pht = ctrl[2];
        ghr_load                 = ctrl[1];
        bht_load                 = ctrl[0];
    endtask

    // Called just after a rising edge: drive, check IF at the falling edge,
    // then check the ID outputs produced by the next rising edge.
    task automatic apply(input vec_t v);
        sb_t s;
        sb_t got;
        drive(v.pc, v.ctrl);
        s.name   = v.name;
        s.exp_id = v.exp[2:0];
        sb_q.push_back(s);
        @(negedge clk);
        check({v.name, ".if_br_pr"}, if_br_pr, v.exp[3]);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s.scoreboard: got empty queue, expected entry", v.name);
        end else begin
            n_pass++;
            got = sb_q.pop_front();
            check({got.name, ".id_local_pr"},  id_local_pr,  got.exp_id[2]);
            check({got.name, ".id_global_pr"}, id_global_pr, got.exp_id[1]);
            check({got.name, ".id_br_pr"},     id_br_pr,     got.exp_id[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- stimulus table ----------------
        // Reset state, then branch 0x100 resolved taken twice (local PHT[0]
        // 01->10->11, GHR and BHT[0] become 000011).
        add("rst_pc60",  32'h60,  LD,              4'b0000);
        add("b100_cap",  32'h100, LD,              4'b0000);
        add("b100_t1",   32'h100, LD|INC|GL|BL,    4'b0000);
        add("b100_t2",   32'h100, LD|INC|GL|BL,    4'b0000);
        // 0x104: BHT[1] still 0 -> local PHT[0]=3 -> local taken; global 0.
        add("fetch104",  32'h104, LD,              4'b1101);
        // Saturation on 0x88: local PHT[0] (at 3) and global PHT[33] (at 1).
        add("sat_cap",   32'h88,  LD,              4'b1101);
        add("sat_i1",    32'h88,  LD|INC,          4'b1101);
        add("sat_i2",    32'h88,  LD|INC,          4'b1111);
        add("sat_i3",    32'h88,  LD|INC,          4'b1111);
        add("sat_i4",    32'h88,  LD|INC,          4'b1111);
        add("sat_i5",    32'h88,  LD|INC,          4'b1111);
        add("sat_d1",    32'h88,  LD|DEC,          4'b1111);
        add("sat_d2",    32'h88,  LD|DEC,          4'b1111);
        add("sat_d3",    32'h88,  LD|DEC,          4'b0000);
        add("sat_d4",    32'h88,  LD|DEC,          4'b0000);
        add("sat_d5",    32'h88,  LD|DEC,          4'b0000);
        add("sat_up1",   32'h88,  LD|INC,          4'b0000);
        add("sat_up2",   32'h88,  LD|INC,          4'b0000);
        add("sat_chk",   32'h88,  LD,              4'b1111);
        // Chooser at 0x40: local=1 (PHT[0]=2), global=0 (PHT[19]=1).
        add("ch_cap",    32'h40,  LD,              4'b1101);
        add("ch_i1",     32'h40,  LD|TI,           4'b1101);
        add("ch_i2",     32'h40,  LD|TI,           4'b0100);
        add("ch_d1",     32'h40,  LD|TD,           4'b0100);
        add("ch_d2",     32'h40,  LD|TD,           4'b0100);
        add("ch_d3",     32'h40,  LD|TD,           4'b1101);
        add("ch_chk",    32'h40,  LD,              4'b1101);
        // Stall: ID holds 0x88's 1/1/1 while the PC moves.
        add("stall_cap", 32'h88,  LD,              4'b1111);
        add("stall_1",   32'h40,  NONE,            4'b1111);
        add("stall_2",   32'h104, NONE,            4'b1111);
        add("stall_3",   32'h60,  NONE,            4'b1111);
        // Flush beats load; training on an invalid ID changes nothing.
        add("flush",     32'h88,  LD|FL,           4'b1000);
        add("flush_trn", 32'h88,  INC|GL|BL,       4'b1000);
        add("flush_chk", 32'h88,  LD,              4'b1111);
        // Read during write on the same entries (counters 2 -> 1 -> 2).
        add("rdw_dec",   32'h88,  LD|DEC,          4'b1111);
        add("rdw_inc",   32'h88,  LD|INC,          4'b0000);
        add("rdw_chk",   32'h88,  LD,              4'b1111);

        // ---------------- reset entry ----------------
        rst = 1'b0;
        drive(32'h60, NONE);
        #12;
        check("rst_in.id_local_pr",  id_local_pr,  1'b0);
        check("rst_in.id_global_pr", id_global_pr, 1'b0);
        check("rst_in.id_br_pr",     id_br_pr,     1'b0);
        check("rst_in.if_br_pr",     if_br_pr,     1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out.id_br_pr",    id_br_pr,     1'b0);
        check("rst_out.if_br_pr",    if_br_pr,     1'b0);
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        foreach (vecs[i]) apply(vecs[i]);

        // ---------------- asynchronous reset mid-run ----------------
        // Before this, 0x88 predicts taken (PHTs at 2); after reset all
        // counters are back to 01.
        drive(32'h88, NONE);
        #2;
        check("pre_arst.if_br_pr", if_br_pr, 1'b1);
        rst = 1'b0;
        #1;
        check("arst.id_local_pr",  id_local_pr,  1'b0);
        check("arst.id_global_pr", id_global_pr, 1'b0);
        check("arst.id_br_pr",     id_br_pr,     1'b0);
        check("arst.if_br_pr",     if_br_pr,     1'b0);
        if_pc = 32'h104;
        #1;
        check("arst.if_br_pr_104", if_br_pr,     1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
